// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   - arbiter FSM state encoding
//   - default data/conf widths matching tx_module
//   - bit positions of the fields inside the tx_module conf word
package uart_pkg;

    localparam int MAX_UART_DATA_W = 8;
    localparam int TOTAL_CONF_W    = 5;

    // conf word layout: {data[1:0], stop[1:0], parity_en}
    localparam int CONF_PARITY_EN_BIT = 0;
    localparam int CONF_STOP_LSB      = 1;
    localparam int CONF_STOP_W        = 2;
    localparam int CONF_DATA_LSB      = 3;
    localparam int CONF_DATA_W        = 2;

    localparam logic [1:0] ARB_IDLE      = 2'b00;
    localparam logic [1:0] ARB_START     = 2'b01;
    localparam logic [1:0] ARB_WAIT_DONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = ARB_IDLE,
        ST_START     = ARB_START,
        ST_WAIT_DONE = ARB_WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req          in  NUM_REQ   request vector
//   ptr          in  REQ_ID_W  highest-priority index for this pick
//   grant_onehot out NUM_REQ   one-hot winner (all zero if none)
//   grant_id     out REQ_ID_W  winner index (0 if none)
//   any          out 1         at least one request present
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_ID_W-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic [REQ_ID_W-1:0] grant_id,
    output logic                any
);

    always_comb begin
        int idx;
        idx          = 0;
        grant_onehot = '0;
        grant_id     = '0;
        any          = 1'b0;
        // Walk from ptr upward with wrap; the modulo also keeps an
        // out-of-range ptr from ever selecting a non-existent requester.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = REQ_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one tx_module between NUM_REQ requesters.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | no character owned; grant round-robin winner if enabled
//   START     | tx_start_o held high until tx_module reports busy
//   WAIT_DONE | character in flight; wait for rising edge of tx_done_i
//
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   en_i                     enable new grants
//   req_valid_i/data/conf    packed per-requester character + conf
//   req_ready_o              one-hot accept (combinational in IDLE)
//   tx_en_o/start/data/conf  drive tx_module
//   tx_busy_i, tx_done_i     status from tx_module
//   grant_id_o               current owner
//   busy_o                   not IDLE
//   done_o, done_id_o        one-clock completion pulse + owner index
module tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int REQ_ID_W        = 2,
    parameter int MAX_UART_DATA_W = uart_pkg::MAX_UART_DATA_W,
    parameter int TOTAL_CONF_W    = uart_pkg::TOTAL_CONF_W
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*MAX_UART_DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ*TOTAL_CONF_W-1:0]    req_conf_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               tx_en_o,
    output logic                               tx_start_o,
    output logic [MAX_UART_DATA_W-1:0]         tx_data_o,
    output logic [TOTAL_CONF_W-1:0]            tx_conf_o,
    input  logic                               tx_busy_i,
    input  logic                               tx_done_i,
    output logic [REQ_ID_W-1:0]                grant_id_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [REQ_ID_W-1:0]                done_id_o
);

    arb_state_e                 state_q, state_d;
    logic [REQ_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                       tx_done_q;
    logic [MAX_UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [TOTAL_CONF_W-1:0]    tx_conf_q, tx_conf_d;
    logic [REQ_ID_W-1:0]        grant_id_q, grant_id_d;
    logic                       done_q, done_d;
    logic [REQ_ID_W-1:0]        done_id_q, done_id_d;

    logic [NUM_REQ-1:0]         arb_onehot;
    logic [REQ_ID_W-1:0]        arb_id;
    logic                       arb_any;
    logic                       grant_ok;
    logic                       done_edge;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_rr_arbiter (
        .req          (req_valid_i),
        .ptr          (rr_ptr_q),
        .grant_onehot (arb_onehot),
        .grant_id     (arb_id),
        .any          (arb_any)
    );

    // Grants are held off during the done_o cycle so that there is always
    // at least one idle clock between characters, and during reset so the
    // combinational ready path reads zero immediately.
    assign grant_ok    = (state_q == ST_IDLE) && en_i && !done_q && !rst_i;
    assign req_ready_o = grant_ok ? arb_onehot : '0;
    assign done_edge   = tx_done_i && !tx_done_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_conf_d  = tx_conf_q;
        grant_id_d = grant_id_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok && arb_any) begin
                    tx_data_d  = req_data_i[int'(arb_id)*MAX_UART_DATA_W +: MAX_UART_DATA_W];
                    tx_conf_d  = req_conf_i[int'(arb_id)*TOTAL_CONF_W +: TOTAL_CONF_W];
                    grant_id_d = arb_id;
                    rr_ptr_d   = (int'(arb_id) == NUM_REQ - 1) ? '0 : arb_id + 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                // tx_module only samples start on a baud strobe, so hold it
                // until the transmitter acknowledges with busy.
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // tx_done_i is stretched over a baud period; act on its edge only.
                if (done_edge) begin
                    done_d    = 1'b1;
                    done_id_d = grant_id_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            tx_done_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_conf_q  <= '0;
            grant_id_q <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_done_q  <= tx_done_i;
            tx_data_q  <= tx_data_d;
            tx_conf_q  <= tx_conf_d;
            grant_id_q <= grant_id_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
        end
    end

    assign tx_start_o = (state_q == ST_START);
    assign busy_o     = (state_q != ST_IDLE);
    // An owned character always runs to completion, even if en_i drops.
    assign tx_en_o    = en_i || (state_q != ST_IDLE);
    assign tx_data_o  = tx_data_q;
    assign tx_conf_o  = tx_conf_q;
    assign grant_id_o = grant_id_q;
    assign done_o     = done_q;
    assign done_id_o  = done_id_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter; tx_module status is driven by hand.
module tb_tx_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [19:0] req_conf_i;
    logic [3:0]  req_ready_o;
    logic        tx_en_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic [4:0]  tx_conf_o;
    logic        tx_busy_i;
    logic        tx_done_i;
    logic [1:0]  grant_id_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  done_id_o;

    int n_tests = 0;
    int n_fail  = 0;

    tx_arbiter #(
        .NUM_REQ         (4),
        .REQ_ID_W        (2),
        .MAX_UART_DATA_W (8),
        .TOTAL_CONF_W    (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_conf_i  (req_conf_i),
        .req_ready_o (req_ready_o),
        .tx_en_o     (tx_en_o),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_conf_o   (tx_conf_o),
        .tx_busy_i   (tx_busy_i),
        .tx_done_i   (tx_done_i),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .done_id_o   (done_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Serve one character: expect a grant to exp_id, acknowledge with busy,
    // then raise done for done_len clocks and count done_o pulses.
    task automatic serve(input int exp_id, input logic [7:0] exp_data,
                         input logic [4:0] exp_conf, input int done_len,
                         input logic [3:0] valid_after);
        int wait_cnt = 0;
        int pulses   = 0;
        while (req_ready_o == 4'b0 && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        chk("ready", 32'(req_ready_o), 32'(4'b0001 << exp_id));
        step();
        req_valid_i = valid_after;
        #1;
        chk("ready_one_clk", 32'(req_ready_o), 32'(0));
        chk("start", 32'(tx_start_o), 32'(1));
        chk("busy", 32'(busy_o), 32'(1));
        chk("grant_id", 32'(grant_id_o), 32'(exp_id));
        chk("tx_data", 32'(tx_data_o), 32'(exp_data));
        chk("tx_conf", 32'(tx_conf_o), 32'(exp_conf));
        tx_busy_i = 1'b1;
        step();
        chk("start_release", 32'(tx_start_o), 32'(0));
        step();
        tx_busy_i = 1'b0;
        tx_done_i = 1'b1;
        for (int i = 0; i < done_len; i++) begin
            step();
            if (done_o) pulses++;
            if (i == 0) begin
                chk("done_first", 32'(done_o), 32'(1));
                chk("done_id", 32'(done_id_o), 32'(exp_id));
                chk("no_ready_on_done", 32'(req_ready_o), 32'(0));
            end
        end
        tx_done_i = 1'b0;
        step();
        if (done_o) pulses++;
        chk("done_pulses", 32'(pulses), 32'(1));
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b1;
        req_valid_i = 4'b1111;
        req_data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_conf_i  = {5'd4, 5'd3, 5'd2, 5'd1};
        tx_busy_i   = 1'b0;
        tx_done_i   = 1'b0;

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'(0));
        chk("rst_start", 32'(tx_start_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_tx_en", 32'(tx_en_o), 32'(1));
        chk("rst_data", 32'(tx_data_o), 32'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;

        // all four valid: 0,1,2,3,0
        serve(0, 8'h10, 5'd1, 1, 4'b1111);
        serve(1, 8'h11, 5'd2, 1, 4'b1111);
        serve(2, 8'h12, 5'd3, 1, 4'b1111);
        serve(3, 8'h13, 5'd4, 1, 4'b1111);
        serve(0, 8'h10, 5'd1, 1, 4'b0000);

        // single requester 1 (rr_ptr now 1)
        req_data_i[15:8] = 8'h5A;
        req_conf_i[9:5]  = 5'b11001;
        req_valid_i      = 4'b0010;
        #1;
        serve(1, 8'h5A, 5'b11001, 1, 4'b0000);

        // rr_ptr = 2, valids 0011: wrap to 0 then 1
        req_data_i  = {8'h23, 8'h22, 8'h21, 8'h20};
        req_valid_i = 4'b0011;
        #1;
        serve(0, 8'h20, 5'd1, 1, 4'b0011);
        serve(1, 8'h21, 5'b11001, 1, 4'b0000);

        // en_i dropped during WAIT_DONE
        req_valid_i = 4'b1111;
        #1;
        chk("en_ready", 32'(req_ready_o), 32'(4'b0100));
        step();
        chk("en_start", 32'(tx_start_o), 32'(1));
        tx_busy_i = 1'b1;
        step();
        en_i = 1'b0;
        #1;
        chk("en_hold_tx_en", 32'(tx_en_o), 32'(1));
        chk("en_hold_busy", 32'(busy_o), 32'(1));
        step();
        tx_busy_i = 1'b0;
        tx_done_i = 1'b1;
        step();
        chk("en_done", 32'(done_o), 32'(1));
        chk("en_done_id", 32'(done_id_o), 32'(2));
        tx_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_no_grant", 32'(req_ready_o), 32'(0));
        end
        chk("en_idle_busy", 32'(busy_o), 32'(0));
        chk("en_idle_tx_en", 32'(tx_en_o), 32'(0));
        en_i = 1'b1;
        #1;
        // resumes at rr_ptr = 3; stretched done over 16 clocks
        serve(3, 8'h23, 5'd4, 16, 4'b0000);

        // async reset while in START
        req_valid_i = 4'b0100;
        #1;
        chk("rs_ready", 32'(req_ready_o), 32'(4'b0100));
        step();
        chk("rs_start", 32'(tx_start_o), 32'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("rs_start_clr", 32'(tx_start_o), 32'(0));
        chk("rs_busy_clr", 32'(busy_o), 32'(0));
        chk("rs_grant_clr", 32'(grant_id_o), 32'(0));
        chk("rs_data_clr", 32'(tx_data_o), 32'(0));
        chk("rs_conf_clr", 32'(tx_conf_o), 32'(0));
        chk("rs_ready_clr", 32'(req_ready_o), 32'(0));
        req_valid_i = 4'b1111;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rs_first_ready", 32'(req_ready_o), 32'(4'b0001));
        step();
        chk("rs_first_grant", 32'(grant_id_o), 32'(0));
        chk("rs_first_start", 32'(tx_start_o), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
